// File: rtl/scroll_scheduler.sv
// rtl/scroll_scheduler.sv - view scroll and block-row spawn sequencer.
// SCROLL_TICK_HOLD_EN: when defined, one frame_tick seen during SPAWN is held and serviced on return to IDLE.
module scroll_scheduler #(
    parameter int SCREEN_HEIGHT = 700,
    parameter int MAX_STEP      = 4,
    parameter int BLOCK_SPACING = 70
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [31:0] doodle_y,
    input  logic        spawn_ack,
    output logic [31:0] view_base,
    output logic        new_view,
    output logic        min_y_crossed,
    output logic        game_over,
    output logic        scrolling,
    output logic        spawn_req,
    output logic [31:0] spawn_y
);

    localparam int          HALF       = SCREEN_HEIGHT >> 1;
    localparam logic [32:0] C_HALF     = 33'(HALF);
    localparam logic [32:0] C_SCREEN   = 33'(SCREEN_HEIGHT);
    localparam logic [32:0] C_STEP     = 33'(MAX_STEP);
    localparam logic [31:0] C_STEP32   = 32'(MAX_STEP);
    localparam logic [31:0] C_SCREEN32 = 32'(SCREEN_HEIGHT);
    localparam logic [31:0] C_SPACING  = 32'(BLOCK_SPACING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPAWN,
        S_OVER
    } state_t;

    state_t      r_state;
    logic [31:0] r_view_base;
    logic [31:0] r_next_spawn_y;
    logic [31:0] r_spawn_y;
    logic        r_new_view;
    logic        r_min_y_crossed;
    logic        r_game_over;
    logic        r_scrolling;
    logic        r_spawn_req;

    logic [32:0] w_mid;
    logic [32:0] w_gap;
    logic [31:0] w_step;
    logic        w_spawn_need;
    logic        w_below;
    logic        w_tick;

    // Gap is evaluated in 33 bits so view_base + HALF never wraps.
    assign w_mid        = {1'b0, r_view_base} + C_HALF;
    assign w_gap        = ({1'b0, doodle_y} > w_mid) ? ({1'b0, doodle_y} - w_mid) : 33'd0;
    assign w_step       = (w_gap > C_STEP) ? C_STEP32 : w_gap[31:0];
    assign w_spawn_need = ({1'b0, r_view_base} + C_SCREEN) >= {1'b0, r_next_spawn_y};
    assign w_below      = doodle_y < r_view_base;

`ifdef SCROLL_TICK_HOLD_EN
    logic r_pending_tick;
    assign w_tick = frame_tick | r_pending_tick;
`else
    assign w_tick = frame_tick;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_view_base     <= 32'd0;
            r_next_spawn_y  <= C_SCREEN32;
            r_spawn_y       <= C_SCREEN32;
            r_new_view      <= 1'b0;
            r_min_y_crossed <= 1'b0;
            r_game_over     <= 1'b0;
            r_scrolling     <= 1'b0;
            r_spawn_req     <= 1'b0;
`ifdef SCROLL_TICK_HOLD_EN
            r_pending_tick  <= 1'b0;
`endif
        end else begin
            r_new_view      <= 1'b0;
            r_min_y_crossed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_spawn_need) begin
                        r_state     <= S_SPAWN;
                        r_spawn_req <= 1'b1;
                        r_spawn_y   <= r_next_spawn_y;
`ifdef SCROLL_TICK_HOLD_EN
                        r_pending_tick <= r_pending_tick | frame_tick;
`endif
                    end else if (w_tick) begin
`ifdef SCROLL_TICK_HOLD_EN
                        r_pending_tick <= 1'b0;
`endif
                        if (w_below) begin
                            r_state         <= S_OVER;
                            r_min_y_crossed <= 1'b1;
                            r_game_over     <= 1'b1;
                            r_scrolling     <= 1'b0;
                        end else if (w_gap != 33'd0) begin
                            r_view_base <= r_view_base + w_step;
                            r_new_view  <= 1'b1;
                            r_scrolling <= w_gap > {1'b0, w_step};
                        end else begin
                            r_scrolling <= 1'b0;
                        end
                    end
                end
                S_SPAWN: begin
                    if (spawn_ack) begin
                        r_state        <= S_IDLE;
                        r_spawn_req    <= 1'b0;
                        r_next_spawn_y <= r_next_spawn_y + C_SPACING;
                    end
`ifdef SCROLL_TICK_HOLD_EN
                    if (frame_tick) begin
                        r_pending_tick <= 1'b1;
                    end
`endif
                end
                S_OVER: begin
                    r_spawn_req <= 1'b0;
                    r_scrolling <= 1'b0;
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign view_base     = r_view_base;
    assign new_view      = r_new_view;
    assign min_y_crossed = r_min_y_crossed;
    assign game_over     = r_game_over;
    assign scrolling     = r_scrolling;
    assign spawn_req     = r_spawn_req;
    assign spawn_y       = r_spawn_y;

endmodule

// File: tb/tb_scroll_scheduler.sv
// tb/tb_scroll_scheduler.sv - self-checking bench for scroll_scheduler against a behavioural model.
module tb_scroll_scheduler;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic [31:0] doodle_y;
    logic        spawn_ack;
    logic [31:0] view_base;
    logic        new_view;
    logic        min_y_crossed;
    logic        game_over;
    logic        scrolling;
    logic        spawn_req;
    logic [31:0] spawn_y;

    int checks;
    int failures;

    scroll_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .doodle_y      (doodle_y),
        .spawn_ack     (spawn_ack),
        .view_base     (view_base),
        .new_view      (new_view),
        .min_y_crossed (min_y_crossed),
        .game_over     (game_over),
        .scrolling     (scrolling),
        .spawn_req     (spawn_req),
        .spawn_y       (spawn_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: world-level quantities in plain integers.
    longint m_view;
    longint m_next;
    longint m_y;
    bit     m_req;
    bit     m_over;
    bit     m_newv;
    bit     m_cross;
    bit     m_scroll;
    bit     m_pend;

    function automatic longint f_gap(longint d, longint v);
        return (d > v + 350) ? d - (v + 350) : 0;
    endfunction

    function automatic longint f_min(longint a, longint b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_view <= 0; m_next <= 700; m_y <= 700; m_req <= 0; m_over <= 0;
            m_newv <= 0; m_cross <= 0; m_scroll <= 0; m_pend <= 0;
        end else begin
            m_newv  <= 0;
            m_cross <= 0;
            if (m_over) begin
                m_req <= 0;
            end else if (m_req) begin
                if (spawn_ack) begin
                    m_req  <= 0;
                    m_next <= m_next + 70;
                end
`ifdef SCROLL_TICK_HOLD_EN
                if (frame_tick) m_pend <= 1;
`endif
            end else if (m_view + 700 >= m_next) begin
                m_req <= 1;
                m_y   <= m_next;
`ifdef SCROLL_TICK_HOLD_EN
                if (frame_tick) m_pend <= 1;
`endif
            end else if (frame_tick || m_pend) begin
                m_pend <= 0;
                if (longint'(doodle_y) < m_view) begin
                    m_over <= 1; m_cross <= 1; m_scroll <= 0;
                end else if (f_gap(longint'(doodle_y), m_view) > 0) begin
                    m_view   <= m_view + f_min(f_gap(longint'(doodle_y), m_view), 4);
                    m_newv   <= 1;
                    m_scroll <= f_gap(longint'(doodle_y), m_view) > 4;
                end else begin
                    m_scroll <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("view_base", longint'(view_base), m_view);
        chk("new_view", longint'(new_view), longint'(m_newv));
        chk("min_y_crossed", longint'(min_y_crossed), longint'(m_cross));
        chk("game_over", longint'(game_over), longint'(m_over));
        chk("scrolling", longint'(scrolling), longint'(m_scroll));
        chk("spawn_req", longint'(spawn_req), longint'(m_req));
        if (m_req) chk("spawn_y", longint'(spawn_y), m_y);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    initial begin
        int r;
        checks = 0; failures = 0;
        reset = 1'b0; frame_tick = 1'b0; doodle_y = 32'd349; spawn_ack = 1'b0;
        repeat (3) cycle();
        chk("reset_view", longint'(view_base), 0);
        chk("reset_spawn_y", longint'(spawn_y), 700);
        chk("reset_req", longint'(spawn_req), 0);
        chk("reset_over", longint'(game_over), 0);

        reset = 1'b1;
        cycle();
        chk("init_req", longint'(spawn_req), 1);
        chk("init_spawn_y", longint'(spawn_y), 700);
        repeat (5) begin tick(); cycle(); end
        chk("idle_ticks_view", longint'(view_base), 0);
        spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
        chk("ack_req_low", longint'(spawn_req), 0);
        cycle();

        doodle_y = 32'd360;
        tick();
        chk("scroll1_view", longint'(view_base), 4);
        chk("scroll1_flag", longint'(scrolling), 1);
        tick(); tick();
        chk("scroll3_view", longint'(view_base), 10);
        chk("scroll3_flag", longint'(scrolling), 0);
        tick();
        chk("scroll4_view", longint'(view_base), 10);
        chk("scroll4_newview", longint'(new_view), 0);

        tick();
        chk("eq_half_view", longint'(view_base), 10);
        doodle_y = 32'd10; tick();
        chk("eq_base_over", longint'(game_over), 0);
        doodle_y = 32'd9; tick();
        chk("crossed_pulse", longint'(min_y_crossed), 1);
        chk("crossed_over", longint'(game_over), 1);
        cycle();
        chk("crossed_pulse_end", longint'(min_y_crossed), 0);
        doodle_y = 32'd900;
        repeat (3) begin tick(); cycle(); end
        chk("over_frozen", longint'(view_base), 10);

        reset = 1'b0; cycle(); reset = 1'b1; cycle();
        spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
        doodle_y = 32'd1000;
        for (int i = 0; i < 60 && !spawn_req; i++) begin tick(); cycle(); end
        chk("scroll_to_spawn_req", longint'(spawn_req), 1);
        chk("spawn_770", longint'(spawn_y), 770);
        chk("spawn_770_view", longint'(view_base), 72);
        repeat (5) begin tick(); cycle(); end
        chk("hold_spawn_y", longint'(spawn_y), 770);
        chk("hold_view", longint'(view_base), 72);
        chk("hold_req", longint'(spawn_req), 1);
        spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
        chk("ack2_req_low", longint'(spawn_req), 0);
        cycle();
        chk("ack2_gap_low", longint'(spawn_req), 0);
        for (int i = 0; i < 60 && !spawn_req; i++) begin tick(); cycle(); end
        chk("spawn_840", longint'(spawn_y), 840);

        reset = 1'b0; spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0; reset = 1'b1;
        chk("midreset_req", longint'(spawn_req), 0);
        chk("midreset_view", longint'(view_base), 0);
        chk("midreset_over", longint'(game_over), 0);
        chk("midreset_spawn_y", longint'(spawn_y), 700);

        cycle();
        doodle_y = 32'd353;
        tick();
        spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
        repeat (3) cycle();
`ifdef SCROLL_TICK_HOLD_EN
        chk("held_tick_view", longint'(view_base), 3);
`else
        chk("dropped_tick_view", longint'(view_base), 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom % 100);
            if (r < 2 && m_view >= 5) doodle_y = 32'(m_view - longint'($urandom_range(1, 5)));
            else if (r < 5) doodle_y = 32'(m_view);
            else doodle_y = 32'(m_view + 344 + longint'($urandom_range(0, 20)));
            frame_tick = ($urandom % 4) == 0;
            spawn_ack  = ($urandom % 3) == 0;
            if (m_over && ($urandom % 20) == 0) reset = 1'b0;
            else reset = (($urandom % 600) != 0);
            cycle();
        end
        reset = 1'b1; frame_tick = 1'b0; spawn_ack = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
